fadd_arbiter: RTL and testbench

Shares one `fadd` unit among `N_REQ` requesters and sequences operands and results through it.
- Requests use valid/ready handshakes and are granted round-robin, at most one per cycle into the unit.
- A tag pipeline matched to the unit's latency carries each result to a per-requester response register, held until that requester accepts it.
- The block sits between the FPU-using pipeline clients (ray-tracing datapath lanes) and the single shared adder.

---
 rtl/fpu_arb_pkg.sv | 30 +++
 rtl/fadd_arbiter_rr_pick.sv | 38 +++
 rtl/fadd_arbiter.sv | 136 +++++++++++++
 tb/tb_fadd_arbiter.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_arb_pkg.sv
// Shared types and constants for the fadd arbiter.
//   FLEN      : operand/result width
//   N_REQ_DEF : default requester count
//   IDW       : requester id width, sized for the largest legal N_REQ
//   fpu_tag_t : {valid, id} tag carried alongside each operation
package fpu_arb_pkg;

    localparam int unsigned FLEN      = 32;
    localparam int unsigned N_REQ_DEF = 4;
    localparam int unsigned N_REQ_MAX = 8;

    // Id width for n requesters, never below one bit.
    function automatic int unsigned id_width(input int unsigned n);
        int unsigned w;
        w = 1;
        if (n > 2) begin
            w = 32'($clog2(n));
        end
        return w;
    endfunction

    // One tag type serves every configuration up to N_REQ_MAX.
    localparam int unsigned IDW = id_width(N_REQ_MAX);

    typedef struct packed {
        logic           valid;
        logic [IDW-1:0] id;
    } fpu_tag_t;

endpackage

// File: rtl/fadd_arbiter_rr_pick.sv
// Combinational round-robin selector.
//   elig  : eligible requesters
//   ptr   : highest-priority position for this cycle
//   grant : one-hot grant (zero when nothing is eligible)
//   idx   : index of the granted requester (zero when no grant)
module rr_pick
    import fpu_arb_pkg::*;
#(
    parameter int unsigned N_REQ = N_REQ_DEF
) (
    input  logic [N_REQ-1:0] elig,
    input  logic [IDW-1:0]   ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IDW-1:0]   idx
);

    int unsigned cand;
    logic        found;

    // Scan positions ptr, ptr+1, ... modulo N_REQ and take the first eligible one.
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            cand = (32'(ptr) + k) % N_REQ;
            for (int unsigned i = 0; i < N_REQ; i++) begin
                if (!found && (cand == i) && elig[i]) begin
                    grant[i] = 1'b1;
                    idx      = IDW'(i);
                    found    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/fadd_arbiter.sv
// Shares one external fadd unit among N_REQ requesters.
//   clk, rstn          : clock, asynchronous active-low reset
//   req_valid/ready    : per-requester operation handshake (ready is a one-hot grant)
//   req_x1, req_x2     : packed operands, requester i at [32i+31:32i]
//   fadd_x1, fadd_x2   : registered operands to the shared adder (zero when idle)
//   fadd_y             : adder result, valid LAT cycles after operands
//   rsp_valid/ready    : per-requester result handshake
//   rsp_y              : packed per-requester result registers
module fadd_arbiter
    import fpu_arb_pkg::*;
#(
    parameter int unsigned N_REQ = N_REQ_DEF,
    parameter int unsigned LAT   = 1
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*FLEN-1:0]   req_x1,
    input  logic [N_REQ*FLEN-1:0]   req_x2,
    output logic [N_REQ-1:0]        req_ready,
    output logic [FLEN-1:0]         fadd_x1,
    output logic [FLEN-1:0]         fadd_x2,
    input  logic [FLEN-1:0]         fadd_y,
    output logic [N_REQ-1:0]        rsp_valid,
    output logic [N_REQ*FLEN-1:0]   rsp_y,
    input  logic [N_REQ-1:0]        rsp_ready
);

    logic [N_REQ-1:0]      pending;
    logic [N_REQ-1:0]      pending_d;
    logic [IDW-1:0]        ptr;
    logic [IDW-1:0]        ptr_d;
    fpu_tag_t              tag   [0:LAT];
    fpu_tag_t              tag_d [0:LAT];
    logic [FLEN-1:0]       x1_d;
    logic [FLEN-1:0]       x2_d;
    logic [N_REQ-1:0]      rsp_valid_d;
    logic [N_REQ*FLEN-1:0] rsp_y_d;

    logic [N_REQ-1:0]      drain;
    logic [N_REQ-1:0]      elig;
    logic [N_REQ-1:0]      pick_grant;
    logic [IDW-1:0]        pick_idx;
    logic                  granted;

    // A slot that empties this cycle may take a new operation on the same edge.
    assign drain = rsp_valid & rsp_ready;
    assign elig  = req_valid & (~pending | drain);

    rr_pick #(
        .N_REQ (N_REQ)
    ) u_pick (
        .elig  (elig),
        .ptr   (ptr),
        .grant (pick_grant),
        .idx   (pick_idx)
    );

    // No grants while reset is held, even though the pick logic sees cleared state.
    assign req_ready = rstn ? pick_grant : '0;
    assign granted   = |req_ready;

    // Next-state: operand mux, pointer, pending flags, tag shift, result capture.
    always_comb begin
        pending_d   = pending;
        ptr_d       = ptr;
        x1_d        = '0;
        x2_d        = '0;
        rsp_valid_d = rsp_valid;
        rsp_y_d     = rsp_y;
        for (int unsigned k = 0; k <= LAT; k++) begin
            tag_d[k] = '0;
        end

        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (req_ready[i]) begin
                x1_d = req_x1[i*FLEN +: FLEN];
                x2_d = req_x2[i*FLEN +: FLEN];
            end
        end

        if (granted) begin
            ptr_d = (pick_idx == IDW'(N_REQ - 1)) ? '0 : pick_idx + IDW'(1);
        end

        // A grant on the drain edge re-arms the flag.
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (req_ready[i]) begin
                pending_d[i] = 1'b1;
            end else if (drain[i]) begin
                pending_d[i] = 1'b0;
            end
        end

        tag_d[0] = '{valid: granted, id: pick_idx};
        for (int unsigned k = 1; k <= LAT; k++) begin
            tag_d[k] = tag[k-1];
        end

        // One outstanding op per requester: the target slot is free or draining now.
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (tag[LAT].valid && (tag[LAT].id == IDW'(i))) begin
                rsp_valid_d[i]            = 1'b1;
                rsp_y_d[i*FLEN +: FLEN]   = fadd_y;
            end else if (drain[i]) begin
                rsp_valid_d[i] = 1'b0;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pending   <= '0;
            ptr       <= '0;
            fadd_x1   <= '0;
            fadd_x2   <= '0;
            rsp_valid <= '0;
            rsp_y     <= '0;
            for (int unsigned k = 0; k <= LAT; k++) begin
                tag[k] <= '0;
            end
        end else begin
            pending   <= pending_d;
            ptr       <= ptr_d;
            fadd_x1   <= x1_d;
            fadd_x2   <= x2_d;
            rsp_valid <= rsp_valid_d;
            rsp_y     <= rsp_y_d;
            for (int unsigned k = 0; k <= LAT; k++) begin
                tag[k] <= tag_d[k];
            end
        end
    end

endmodule

// File: tb/tb_fadd_arbiter.sv
// Self-checking bench for fadd_arbiter with a behavioural single-precision adder.
module tb_fadd_arbiter;
    import fpu_arb_pkg::*;

    localparam int unsigned NR   = 4;
    localparam int unsigned LATC = 1;

    logic              clk = 1'b0;
    logic              rstn;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR*32-1:0]  req_x1;
    logic [NR*32-1:0]  req_x2;
    logic [31:0]       fadd_x1;
    logic [31:0]       fadd_x2;
    logic [31:0]       fadd_y;
    logic [NR-1:0]     rsp_valid;
    logic [NR*32-1:0]  rsp_y;
    logic [NR-1:0]     rsp_ready;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    fadd_arbiter #(
        .N_REQ (NR),
        .LAT   (LATC)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .req_valid (req_valid),
        .req_x1    (req_x1),
        .req_x2    (req_x2),
        .req_ready (req_ready),
        .fadd_x1   (fadd_x1),
        .fadd_x2   (fadd_x2),
        .fadd_y    (fadd_y),
        .rsp_valid (rsp_valid),
        .rsp_y     (rsp_y),
        .rsp_ready (rsp_ready)
    );

    // ---------------- behavioural adder (normal numbers, truncating) ----------------
    function automatic real sp2real(input logic [31:0] f);
        logic [63:0] d;
        if (f[30:23] == 8'd0) return 0.0;
        d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] real2sp(input real r);
        logic [63:0] d;
        d = $realtobits(r);
        if (d[62:52] == 11'd0) return 32'h0;
        return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
    endfunction

    function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
        return real2sp(sp2real(a) + sp2real(b));
    endfunction

    function automatic logic [31:0] rand_fp();
        return {1'($urandom_range(0, 1)), 8'($urandom_range(120, 134)), 23'($urandom)};
    endfunction

    logic [31:0] add_pipe [LATC];
    always @(posedge clk) begin
        add_pipe[0] <= fp_add(fadd_x1, fadd_x2);
        for (int k = 1; k < LATC; k++) add_pipe[k] <= add_pipe[k-1];
    end
    assign fadd_y = add_pipe[LATC-1];

    // ---------------- scoreboard monitor ----------------
    typedef struct {
        logic [31:0] y;
        int          due;
    } exp_t;

    exp_t          sb [NR][$];
    logic [NR-1:0] outst = '0;
    logic [NR-1:0] seen  = '0;
    logic [NR-1:0] elig_m;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (!rstn) begin
            for (int i = 0; i < NR; i++) sb[i].delete();
            outst = '0;
            seen  = '0;
        end else begin
            elig_m = req_valid & (~outst | (rsp_valid & rsp_ready));
            for (int i = 0; i < NR; i++) begin
                if (sb[i].size() != 0 && !seen[i]) begin
                    total++;
                    if (rsp_valid[i]) begin
                        seen[i] = 1'b1;
                        if (cyc != sb[i][0].due) begin
                            bad++;
                            $display("FAIL rsp_latency[%0d]: got cycle %0d want cycle %0d", i, cyc, sb[i][0].due);
                        end
                    end else if (cyc > sb[i][0].due) begin
                        bad++;
                        seen[i] = 1'b1;
                        $display("FAIL rsp_late[%0d]: no rsp_valid by cycle %0d", i, sb[i][0].due);
                    end
                end else if (sb[i].size() == 0) begin
                    total++;
                    if (rsp_valid[i]) begin
                        bad++;
                        $display("FAIL rsp_spurious[%0d]: rsp_valid=1 want 0", i);
                    end
                end
                if (rsp_valid[i] && rsp_ready[i] && sb[i].size() != 0) begin
                    total++;
                    if (rsp_y[i*32 +: 32] !== sb[i][0].y) begin
                        bad++;
                        $display("FAIL rsp_data[%0d]: got %h want %h", i, rsp_y[i*32 +: 32], sb[i][0].y);
                    end
                    void'(sb[i].pop_front());
                    seen[i]  = 1'b0;
                    outst[i] = 1'b0;
                end
            end
            total++;
            if (((req_ready & ~elig_m) != '0) || ($countones(req_ready) > 1)) begin
                bad++;
                $display("FAIL grant_legal: req_ready=%b want one-hot subset of %b", req_ready, elig_m);
            end
            total++;
            if (elig_m != '0 && req_ready == '0) begin
                bad++;
                $display("FAIL grant_missing: req_ready=%b want a grant from %b", req_ready, elig_m);
            end
            for (int i = 0; i < NR; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    sb[i].push_back('{y: fp_add(req_x1[i*32 +: 32], req_x2[i*32 +: 32]),
                                      due: cyc + int'(LATC) + 2});
                    outst[i] = 1'b1;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_ops(input int i, input logic [31:0] a, input logic [31:0] b);
        req_x1[i*32 +: 32] = a;
        req_x2[i*32 +: 32] = b;
    endtask

    task automatic randomize_ops();
        for (int i = 0; i < NR; i++) set_ops(i, rand_fp(), rand_fp());
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle(input int n);
        req_valid = '0;
        rsp_ready = '1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rstn      = 1'b0;
        req_valid = '1;
        rsp_ready = '0;
        randomize_ops();
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++; if (req_ready !== '0) begin bad++; $display("FAIL reset_req_ready: got %b want 0", req_ready); end
        total++; if (fadd_x1 !== 32'h0) begin bad++; $display("FAIL reset_fadd_x1: got %h want 0", fadd_x1); end
        total++; if (fadd_x2 !== 32'h0) begin bad++; $display("FAIL reset_fadd_x2: got %h want 0", fadd_x2); end
        total++; if (rsp_valid !== '0) begin bad++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        total++; if (rsp_y !== '0) begin bad++; $display("FAIL reset_rsp_y: got %h want 0", rsp_y); end
        total++; if (dut.ptr !== IDW'(0)) begin bad++; $display("FAIL reset_ptr: got %0d want 0", dut.ptr); end
        next_cycle();
        rstn      = 1'b1;
        req_valid = '0;
        @(negedge clk);
        total++; if (rsp_valid !== '0) begin bad++; $display("FAIL release_rsp_valid: got %b want 0", rsp_valid); end
        next_cycle();
    endtask

    task automatic test_all_together();
        logic [NR-1:0] exp_g;
        req_valid = '1;
        rsp_ready = '1;
        for (int c = 0; c < 16; c++) begin
            randomize_ops();
            set_ops(2, 32'h3F000000, 32'h3F800000);
            @(negedge clk);
            exp_g = NR'(1) << (c % NR);
            total++;
            if (req_ready !== exp_g) begin
                bad++;
                $display("FAIL all_grant_order[%0d]: got %b want %b", c, req_ready, exp_g);
            end
            if (rsp_valid[2]) begin
                total++;
                if (rsp_y[64 +: 32] !== 32'h3FC00000) begin
                    bad++;
                    $display("FAIL all_rsp2_value: got %h want 3fc00000", rsp_y[64 +: 32]);
                end
            end
            next_cycle();
        end
        settle(5);
    endtask

    task automatic test_single();
        rsp_ready = '0;
        req_valid = '0;
        set_ops(0, 32'h3F800000, 32'h40000000);
        req_valid[0] = 1'b1;
        @(negedge clk);
        total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL single_grant: got %b want 0001", req_ready); end
        next_cycle();
        req_valid[0] = 1'b0;
        @(negedge clk);
        total++; if (fadd_x1 !== 32'h3F800000) begin bad++; $display("FAIL single_fadd_x1: got %h want 3f800000", fadd_x1); end
        total++; if (fadd_x2 !== 32'h40000000) begin bad++; $display("FAIL single_fadd_x2: got %h want 40000000", fadd_x2); end
        total++; if (rsp_valid !== '0) begin bad++; $display("FAIL single_early1: got %b want 0", rsp_valid); end
        @(negedge clk);
        total++; if (rsp_valid !== '0) begin bad++; $display("FAIL single_early2: got %b want 0", rsp_valid); end
        @(negedge clk);
        total++; if (rsp_valid !== 4'b0001) begin bad++; $display("FAIL single_rsp_valid: got %b want 0001", rsp_valid); end
        total++; if (rsp_y[31:0] !== 32'h40400000) begin bad++; $display("FAIL single_rsp_y: got %h want 40400000", rsp_y[31:0]); end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total++; if (rsp_valid[0] !== 1'b1) begin bad++; $display("FAIL single_hold[%0d]: got %b want 1", c, rsp_valid[0]); end
        end
        next_cycle();
        rsp_ready[0] = 1'b1;
        next_cycle();
        rsp_ready = '0;
        @(negedge clk);
        total++; if (rsp_valid !== '0) begin bad++; $display("FAIL single_release: got %b want 0", rsp_valid); end
        next_cycle();
    endtask

    task automatic test_slot_held();
        logic got;
        logic regrant;
        // Contended: requester 1 holds its result, others keep flowing.
        rsp_ready = 4'b1101;
        req_valid = '1;
        randomize_ops();
        @(negedge clk);
        total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL held_first_grant: got %b want 0010", req_ready); end
        got = 1'b0;
        for (int c = 0; c < 8 && !got; c++) begin
            next_cycle();
            randomize_ops();
            @(negedge clk);
            if (rsp_valid[1]) got = 1'b1;
        end
        total++; if (!got) begin bad++; $display("FAIL held_rsp_timeout: got no rsp_valid[1] want 1"); end
        for (int c = 0; c < 5; c++) begin
            if (c > 0) @(negedge clk);
            total++;
            if (req_ready[1] !== 1'b0 || req_ready === '0 || rsp_valid[1] !== 1'b1) begin
                bad++;
                $display("FAIL held_block[%0d]: req_ready=%b rsp_valid=%b want bit1 clear, others granted, rsp_valid[1]=1",
                         c, req_ready, rsp_valid);
            end
            next_cycle();
            randomize_ops();
        end
        rsp_ready[1] = 1'b1;
        regrant = 1'b0;
        for (int c = 0; c < NR + 1 && !regrant; c++) begin
            @(negedge clk);
            if (req_ready[1]) regrant = 1'b1;
            next_cycle();
        end
        total++; if (!regrant) begin bad++; $display("FAIL held_regrant: got no grant to 1 want grant within %0d cycles", NR + 1); end
        settle(6);

        // Uncontended: re-grant lands on the accept edge itself.
        rsp_ready = '0;
        req_valid = 4'b0010;
        set_ops(1, rand_fp(), rand_fp());
        @(negedge clk);
        total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL b2b_first: got %b want 0010", req_ready); end
        next_cycle();
        set_ops(1, rand_fp(), rand_fp());
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total++; if (req_ready !== '0) begin bad++; $display("FAIL b2b_pending[%0d]: got %b want 0", c, req_ready); end
        end
        total++; if (rsp_valid[1] !== 1'b1) begin bad++; $display("FAIL b2b_rsp: got %b want 1", rsp_valid[1]); end
        next_cycle();
        rsp_ready[1] = 1'b1;
        @(negedge clk);
        total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL b2b_same_edge: got %b want 0010", req_ready); end
        next_cycle();
        rsp_ready = '0;
        req_valid = '0;
        @(negedge clk);
        total++; if (rsp_valid[1] !== 1'b0) begin bad++; $display("FAIL b2b_cleared: got %b want 0", rsp_valid[1]); end
        settle(5);
    endtask

    task automatic test_fairness();
        rsp_ready = '1;
        req_valid = 4'b0100;
        randomize_ops();
        @(negedge clk);
        total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL fair_setup: got %b want 0100", req_ready); end
        next_cycle();
        settle(5);
        req_valid = 4'b1001;
        @(negedge clk);
        total++; if (req_ready !== 4'b1000) begin bad++; $display("FAIL fair_first: got %b want 1000", req_ready); end
        next_cycle();
        @(negedge clk);
        total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL fair_second: got %b want 0001", req_ready); end
        next_cycle();
        req_valid = '0;
        @(negedge clk);
        total++; if (dut.ptr !== IDW'(1)) begin bad++; $display("FAIL fair_ptr: got %0d want 1", dut.ptr); end
        settle(5);
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            req_valid = NR'($urandom);
            rsp_ready = NR'($urandom);
            randomize_ops();
            next_cycle();
        end
        settle(8);
        for (int i = 0; i < NR; i++) begin
            total++;
            if (sb[i].size() != 0) begin
                bad++;
                $display("FAIL rand_drain[%0d]: got %0d outstanding want 0", i, sb[i].size());
            end
        end
    endtask

    task automatic test_reset_mid();
        rsp_ready = '1;
        req_valid = 4'b0001;
        randomize_ops();
        @(negedge clk);
        total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL rmid_grant: got %b want 0001", req_ready); end
        next_cycle();
        req_valid = '0;
        next_cycle();
        rstn      = 1'b0;
        req_valid = '1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            total++;
            if (req_ready !== '0 || fadd_x1 !== 32'h0 || fadd_x2 !== 32'h0 || rsp_valid !== '0 || rsp_y !== '0) begin
                bad++;
                $display("FAIL rmid_in_reset[%0d]: req_ready=%b fadd_x1=%h fadd_x2=%h rsp_valid=%b want all 0",
                         c, req_ready, fadd_x1, fadd_x2, rsp_valid);
            end
            total++; if (dut.ptr !== IDW'(0)) begin bad++; $display("FAIL rmid_ptr: got %0d want 0", dut.ptr); end
            next_cycle();
        end
        rstn      = 1'b1;
        req_valid = '0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            total++;
            if (rsp_valid !== '0 || fadd_x1 !== 32'h0 || fadd_x2 !== 32'h0) begin
                bad++;
                $display("FAIL rmid_after[%0d]: rsp_valid=%b fadd_x1=%h fadd_x2=%h want 0", c, rsp_valid, fadd_x1, fadd_x2);
            end
            next_cycle();
        end
    endtask

    task automatic test_idle();
        req_valid = '0;
        rsp_ready = '0;
        for (int c = 0; c < 10; c++) begin
            randomize_ops();
            @(negedge clk);
            total++;
            if (fadd_x1 !== 32'h0 || fadd_x2 !== 32'h0 || rsp_valid !== '0 || req_ready !== '0) begin
                bad++;
                $display("FAIL idle[%0d]: fadd_x1=%h fadd_x2=%h rsp_valid=%b req_ready=%b want 0",
                         c, fadd_x1, fadd_x2, rsp_valid, req_ready);
            end
            next_cycle();
        end
        @(negedge clk);
        total++; if (dut.ptr !== IDW'(0)) begin bad++; $display("FAIL idle_ptr: got %0d want 0", dut.ptr); end
    endtask

    initial begin
        rstn      = 1'b0;
        req_valid = '0;
        rsp_ready = '0;
        req_x1    = '0;
        req_x2    = '0;
        test_reset();
        test_all_together();
        test_single();
        test_slot_held();
        test_fairness();
        test_random();
        test_reset_mid();
        test_idle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
